// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
// Rotate modes are only decoded when USR_ROTATE_EN is defined.
package usr_pkg;

  typedef enum logic [2:0] {
    USR_HOLD = 3'b000,
    USR_SHR  = 3'b001,
    USR_SHL  = 3'b010,
    USR_LOAD = 3'b011,
    USR_ROR  = 3'b100,
    USR_ROL  = 3'b101,
    USR_CLR  = 3'b110,
    USR_RSVD = 3'b111
  } usr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } usr_state_e;

endpackage

// File: rtl/univ_shift_reg_bit_mux.sv
// Per-bit next-value selector for univ_shift_reg; neighbour bits arrive pre-wired.
// Rotate inputs exist only when USR_ROTATE_EN is defined.
module usr_bit_mux
  import usr_pkg::*;
(
  input  usr_mode_e i_mode,
  input  logic      i_cur,
  input  logic      i_d,
  input  logic      i_hi,
  input  logic      i_lo,
`ifdef USR_ROTATE_EN
  input  logic      i_hi_rot,
  input  logic      i_lo_rot,
`endif
  output logic      o_nxt
);

  always_comb begin
    o_nxt = i_cur;
    case (i_mode)
      USR_SHR:  o_nxt = i_hi;
      USR_SHL:  o_nxt = i_lo;
      USR_LOAD: o_nxt = i_d;
`ifdef USR_ROTATE_EN
      USR_ROR:  o_nxt = i_hi_rot;
      USR_ROL:  o_nxt = i_lo_rot;
`endif
      USR_CLR:  o_nxt = 1'b0;
      default:  o_nxt = i_cur;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift/rotate/load/clear and an LSB-first serial burst.
// Define USR_ROTATE_EN to enable modes 100/101 (otherwise they hold).
//
// state    | meaning
// ST_IDLE  | mode operations applied on en; start loads d and begins a burst
// ST_SHIFT | burst running: shift right with ser_msb each enabled edge
// ST_DONE  | one-cycle done pulse, q holds, always returns to idle
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_ser_msb,
  input  logic             i_ser_lsb,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qb,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  usr_state_e       r_state;

  usr_state_e       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  usr_mode_e        w_op;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
    end
  end

  // The FSM decides which operation the bit muxes see; everything else is HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op        = USR_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          if (i_start) begin
            w_op        = USR_LOAD;
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_op = usr_mode_e'(i_mode);
          end
        end
      end
      ST_SHIFT: begin
        if (i_en) begin
          w_op = USR_SHR;
          if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt <= CW'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_hi = {i_ser_msb, r_q[WIDTH-1:1]};
  assign w_lo = {r_q[WIDTH-2:0], i_ser_lsb};

`ifdef USR_ROTATE_EN
  logic [WIDTH-1:0] w_hi_rot;
  logic [WIDTH-1:0] w_lo_rot;
  assign w_hi_rot = {r_q[0], r_q[WIDTH-1:1]};
  assign w_lo_rot = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_mux u_mux (
      .i_mode   (w_op),
      .i_cur    (r_q[i]),
      .i_d      (i_d[i]),
      .i_hi     (w_hi[i]),
      .i_lo     (w_lo[i]),
`ifdef USR_ROTATE_EN
      .i_hi_rot (w_hi_rot[i]),
      .i_lo_rot (w_lo_rot[i]),
`endif
      .o_nxt    (w_q_nxt[i])
    );
  end

  assign o_q    = r_q;
  assign o_qb   = ~r_q;
  assign o_sout = r_q[0];
  assign o_busy = (r_state == ST_SHIFT);
  assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=A5): mode table plus burst sequences.
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000, M_SHR = 3'b001, M_SHL = 3'b010, M_LOAD = 3'b011,
                         M_ROR  = 3'b100, M_ROL = 3'b101, M_CLR = 3'b110, M_RSVD = 3'b111;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk, rst, en, ser_msb, ser_lsb, start;
  logic [2:0] mode;
  logic [7:0] d, q, qb;
  logic       sout, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       msb;
    logic       lsb;
    logic [7:0] eq;
  } vec_t;
  vec_t tbl[17];

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
    .i_ser_msb(ser_msb), .i_ser_lsb(ser_lsb), .i_start(start),
    .o_q(q), .o_qb(qb), .o_sout(sout), .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      cmp({name, ".q"}, q, e.q);
      cmp({name, ".qb"}, qb, ~e.q);
      cmp({name, ".sout"}, {7'd0, sout}, {7'd0, e.q[0]});
      cmp({name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
      cmp({name, ".done"}, {7'd0, done}, {7'd0, e.done});
    end
  endtask

  task automatic step(input string name, input logic e_en, input logic [2:0] e_mode,
                      input logic [7:0] e_d, input logic e_msb, input logic e_lsb,
                      input logic e_start, input logic [7:0] eq, input logic eb, input logic ed);
    en = e_en; mode = e_mode; d = e_d; ser_msb = e_msb; ser_lsb = e_lsb; start = e_start;
    sb.push_back('{q: eq, busy: eb, done: ed});
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    logic [7:0] rot_l, rot_r, mq, pat;
    int         cnt;
    logic       en_c;

`ifdef USR_ROTATE_EN
    rot_l = 8'h03; rot_r = 8'hC0;
`else
    rot_l = 8'h81; rot_r = 8'h81;
`endif
    tbl[0]  = '{1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C};
    tbl[1]  = '{1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 8'h3C};
    tbl[2]  = '{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    tbl[3]  = '{1'b1, M_SHL,  8'h00, 1'b0, 1'b1, 8'h03};
    tbl[4]  = '{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    tbl[5]  = '{1'b1, M_SHR,  8'h00, 1'b0, 1'b1, 8'h40};
    tbl[6]  = '{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    tbl[7]  = '{1'b1, M_ROL,  8'h00, 1'b1, 1'b0, rot_l};
    tbl[8]  = '{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    tbl[9]  = '{1'b1, M_ROR,  8'h00, 1'b0, 1'b1, rot_r};
    tbl[10] = '{1'b1, M_CLR,  8'hFF, 1'b1, 1'b1, 8'h00};
    tbl[11] = '{1'b1, M_LOAD, 8'h5A, 1'b0, 1'b0, 8'h5A};
    tbl[12] = '{1'b1, M_RSVD, 8'hFF, 1'b1, 1'b1, 8'h5A};
    tbl[13] = '{1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1, 8'h5A};
    tbl[14] = '{1'b1, M_SHR,  8'h00, 1'b1, 1'b0, 8'hAD};
    tbl[15] = '{1'b1, M_SHL,  8'h00, 1'b1, 1'b0, 8'h5A};
    tbl[16] = '{1'b0, M_CLR,  8'h00, 1'b0, 1'b0, 8'h5A};

    rst = 1'b1; en = 1'b0; mode = M_HOLD; d = 8'h00; ser_msb = 1'b0; ser_lsb = 1'b0; start = 1'b0;
    sb.push_back('{q: RV, busy: 1'b0, done: 1'b0});
    #3;
    check("reset");
    #1 rst = 1'b0;

    for (int i = 0; i < 17; i++)
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].msb, tbl[i].lsb,
           1'b0, tbl[i].eq, 1'b0, 1'b0);

    // Burst 1: start wins over a simultaneous CLR; restart and mode mid-burst are ignored.
    pat = 8'hB4;
    step("burst1.e0", 1'b1, M_CLR, pat, 1'b0, 1'b0, 1'b1, pat, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++)
      step($sformatf("burst1.e%0d", k), 1'b1, (k == 3) ? M_CLR : M_HOLD, 8'h00, 1'b0, 1'b0,
           (k == 2), pat >> k, 1'b1, 1'b0);
    step("burst1.e8", 1'b1, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step("burst1.done_start", 1'b1, M_HOLD, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("burst1.idle", 1'b1, M_HOLD, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Burst 2: ser_msb=1 with three en=0 cycles; done moves three cycles later.
    mq = pat; cnt = 8;
    step("burst2.e0", 1'b1, M_HOLD, pat, 1'b1, 1'b0, 1'b1, mq, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      en_c = !(c >= 4 && c <= 6);
      if (en_c && cnt > 0) begin
        mq = {1'b1, mq[7:1]};
        cnt--;
      end
      step($sformatf("burst2.c%0d", c), en_c, M_LOAD, 8'h00, 1'b1, 1'b0, 1'b0,
           mq, (cnt != 0), (c == 11));
    end
    step("burst2.done_en0", 1'b0, M_HOLD, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Abort: reset after four shifts, no done afterwards.
    step("abort.e0", 1'b1, M_HOLD, pat, 1'b0, 1'b0, 1'b1, pat, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++)
      step($sformatf("abort.e%0d", k), 1'b1, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, pat >> k, 1'b1, 1'b0);
    #3 rst = 1'b1;
    sb.push_back('{q: RV, busy: 1'b0, done: 1'b0});
    #1;
    check("abort.rst");
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++)
      step($sformatf("abort.after%0d", k), 1'b1, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, RV, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

endmodule
